// File: rtl/xbar_pkg.sv
// Shared definitions for the bus master port.
//   state_e   : master_port FSM states (IDLE, REQ, RDATA, RSP)
//   CMD_READ  : bus command encoding for a read
//   CMD_WRITE : bus command encoding for a write
package xbar_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        REQ   = 2'd1,
        RDATA = 2'd2,
        RSP   = 2'd3
    } state_e;

    localparam logic CMD_READ  = 1'b0;
    localparam logic CMD_WRITE = 1'b1;

endpackage

// File: rtl/master_port_if.sv
// Bundle of the local command/response handshake and the master_1 bus.
//   modport master : the master_port side (accepts commands, drives the bus)
//   modport slave  : the opposite side (issues commands, responds on the bus)
interface master_port_if;

    logic        cmd_valid;
    logic        cmd_ready;
    logic        cmd_write;
    logic [31:0] cmd_addr;
    logic [31:0] cmd_wdata;

    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_err;

    logic        master_1_req;
    logic [31:0] master_1_addr;
    logic        master_1_cmd;
    logic [31:0] master_1_wdata;
    logic        master_1_ack;
    logic [31:0] master_1_rdata;

    modport master (
        input  cmd_valid, cmd_write, cmd_addr, cmd_wdata,
        output cmd_ready,
        output rsp_valid, rsp_rdata, rsp_err,
        output master_1_req, master_1_addr, master_1_cmd, master_1_wdata,
        input  master_1_ack, master_1_rdata
    );

    modport slave (
        output cmd_valid, cmd_write, cmd_addr, cmd_wdata,
        input  cmd_ready,
        input  rsp_valid, rsp_rdata, rsp_err,
        input  master_1_req, master_1_addr, master_1_cmd, master_1_wdata,
        output master_1_ack, master_1_rdata
    );

endinterface

// File: rtl/txn_timer.sv
// Ack-wait timer for master_port.
//   clk, resetn : clock, asynchronous active-low reset
//   clear_i     : force the count to zero (wins over enable_i)
//   enable_i    : advance the count by one this cycle
//   expired_o   : count has reached TIMEOUT-1
module txn_timer #(
    parameter int TIMEOUT = 64,
    parameter int CNT_W   = 16
) (
    input  logic clk,
    input  logic resetn,
    input  logic clear_i,
    input  logic enable_i,
    output logic expired_o
);

    logic [CNT_W-1:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (clear_i) begin
            count_d = '0;
        end else if (enable_i) begin
            count_d = count_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    // Count is 0 in the first REQ cycle, so expiry at TIMEOUT-1 gives
    // exactly TIMEOUT cycles of req before the abort.
    assign expired_o = (count_q == CNT_W'(TIMEOUT - 1));

endmodule

// File: rtl/master_port.sv
// Single-outstanding bus master port.
//   clk, resetn : clock, asynchronous active-low reset
//   bus         : master_port_if.master -- local cmd/rsp handshake and the
//                 master_1 req/ack bus
//   txn_cnt     : completed transactions (including timeouts), wraps
// A command is accepted in IDLE, presented on master_1 until ack or
// timeout, read data is captured the cycle after ack, and a single-cycle
// response is issued in RSP.
module master_port
    import xbar_pkg::*;
#(
    parameter int TIMEOUT = 64,
    parameter int CNT_W   = 16
) (
    input  logic             clk,
    input  logic             resetn,
    master_port_if.master    bus,
    output logic [CNT_W-1:0] txn_cnt
);

    state_e           state_q, state_d;
    logic             cmd_ready_q, cmd_ready_d;
    logic             req_q, req_d;
    logic             write_q, write_d;
    logic [31:0]      addr_q, addr_d;
    logic [31:0]      wdata_q, wdata_d;
    logic [31:0]      rdata_q, rdata_d;
    logic             err_q, err_d;
    logic [CNT_W-1:0] txn_cnt_q, txn_cnt_d;
    logic             timer_clr, timer_en, timer_expired;

    txn_timer #(
        .TIMEOUT (TIMEOUT),
        .CNT_W   (CNT_W)
    ) u_timer (
        .clk       (clk),
        .resetn    (resetn),
        .clear_i   (timer_clr),
        .enable_i  (timer_en),
        .expired_o (timer_expired)
    );

    always_comb begin
        state_d   = state_q;
        req_d     = req_q;
        write_d   = write_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        rdata_d   = rdata_q;
        err_d     = err_q;
        txn_cnt_d = txn_cnt_q;
        timer_clr = 1'b0;
        timer_en  = 1'b0;

        case (state_q)
            IDLE: begin
                if (bus.cmd_valid && cmd_ready_q) begin
                    addr_d    = bus.cmd_addr;
                    write_d   = bus.cmd_write;
                    wdata_d   = bus.cmd_wdata;
                    req_d     = 1'b1;
                    rdata_d   = '0;
                    err_d     = 1'b0;
                    timer_clr = 1'b1;
                    state_d   = REQ;
                end
            end
            REQ: begin
                timer_en = 1'b1;
                // Ack is checked first so a last-cycle ack is not an error.
                if (bus.master_1_ack) begin
                    req_d   = 1'b0;
                    state_d = (write_q == CMD_WRITE) ? RSP : RDATA;
                end else if (timer_expired) begin
                    req_d   = 1'b0;
                    err_d   = 1'b1;
                    state_d = RSP;
                end
            end
            RDATA: begin
                rdata_d = bus.master_1_rdata;
                state_d = RSP;
            end
            RSP: begin
                txn_cnt_d = txn_cnt_q + 1'b1;
                state_d   = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Registered so that ready stays low while reset is held and rises on
    // the first edge after release.
    assign cmd_ready_d = (state_d == IDLE);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q     <= IDLE;
            cmd_ready_q <= 1'b0;
            req_q       <= 1'b0;
            write_q     <= CMD_READ;
            addr_q      <= '0;
            wdata_q     <= '0;
            rdata_q     <= '0;
            err_q       <= 1'b0;
            txn_cnt_q   <= '0;
        end else begin
            state_q     <= state_d;
            cmd_ready_q <= cmd_ready_d;
            req_q       <= req_d;
            write_q     <= write_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            rdata_q     <= rdata_d;
            err_q       <= err_d;
            txn_cnt_q   <= txn_cnt_d;
        end
    end

    assign bus.cmd_ready      = cmd_ready_q;
    assign bus.master_1_req   = req_q;
    assign bus.master_1_addr  = addr_q;
    assign bus.master_1_cmd   = write_q;
    assign bus.master_1_wdata = wdata_q;
    assign bus.rsp_valid      = (state_q == RSP);
    // Response fields are only meaningful alongside rsp_valid.
    assign bus.rsp_rdata      = (state_q == RSP) ? rdata_q : 32'd0;
    assign bus.rsp_err        = (state_q == RSP) && err_q;
    assign txn_cnt            = txn_cnt_q;

endmodule
